intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Phase scheduler for a two-road intersection with a pedestrian crossing. Shares the crossing area between three requesters: main road (default owner), side road and pedestrians. It sequences the GO / ATTENTION / STOP light states for each requester with per-phase timers. It sits above the light drivers in the traffic controller path. The clock period is the timing unit: one cycle is one second at the system clock.

## Interface
Parameters:
- CNT_W, 8, phase timer width
- MAIN_MIN, 30, minimum main GO cycles before any handover
- SIDE_GO_T, 20, nominal side GO cycles
- SIDE_MAX, 60, maximum side GO cycles, including congestion extension
- PED_T, 15, pedestrian walk cycles
- ATTN_T, 3, length of every ATTENTION phase, in cycles

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- side_req  in  1  side-road demand/congestion level; sampled each cycle, not latched
- ped_req  in  1  pedestrian button; a one-cycle pulse is sufficient
- main_state  out  2  main-road light
- side_state  out  2  side-road light
- ped_walk  out  1  pedestrian walk signal

## Operation
- Light encoding: 00 STOP, 01 STOP-ATTENTION (red+yellow), 10 GO, 11 GO-ATTENTION (yellow).
- FSM states and outputs (main/side/walk):
  - MAIN_GO 10/00/0
  - MAIN_ATTN 11/00/0
  - SIDE_PREP 00/01/0
  - SIDE_GO 00/10/0
  - SIDE_ATTN 00/11/0
  - PED 00/00/1
  - MAIN_PREP 01/00/0
- Outputs are a pure decode of the state register. No glitch-free extra register is required.
- timer: CNT_W-bit counter. It clears to 0 on every state change and otherwise increments.
- MAIN_GO exit:
  - Leaves when timer ≥ MAIN_MIN-1 and (side_req | ped_pend).
  - Otherwise it rests in MAIN_GO indefinitely. The timer saturates at all-ones and never wraps.
- On MAIN_GO exit, register target (side or ped):
  - Only one requester active: that requester.
  - Both active: round-robin flag rr decides. rr=0 selects side, rr=1 selects ped. rr toggles after each such tie.
- MAIN_ATTN → SIDE_PREP or PED (per target) after ATTN_T cycles.
- SIDE_PREP → SIDE_GO after ATTN_T cycles.
- SIDE_GO exits when timer == SIDE_MAX-1, or when timer ≥ SIDE_GO_T-1 and !side_req. Congestion extends SIDE_GO up to SIDE_MAX.
- SIDE_ATTN → MAIN_PREP after ATTN_T cycles.
- PED → MAIN_PREP after PED_T cycles. The target is committed: if side_req drops during ATTN, the side phase still runs for SIDE_GO_T.
- MAIN_PREP → MAIN_GO after ATTN_T cycles.
- ped_pend:
  - Set by ped_req in any state.
  - Cleared on the cycle PED is entered. Clear wins over a same-cycle ped_req.
  - A ped_req during PED re-arms ped_pend for the next cycle.
- Parameter rules: all ≥ 1, SIDE_MAX ≥ SIDE_GO_T, all < 2^CNT_W. Violations are unsupported.

## Timing
- Reset (rst_n=0 at a clk edge): state MAIN_GO, timer 0, ped_pend 0, rr 0, target side.
- Outputs after reset: main_state=10, side_state=00, ped_walk=0.
- Reset mid-phase takes effect at the next edge regardless of state. No ATTENTION phase is inserted.
- A state with length T is held for exactly T cycles.
- Request to response: side_req high at cycle n in MAIN_GO with timer ≥ MAIN_MIN-1 puts MAIN_ATTN at cycle n+1.
- Worst-case side wait from request to GO: MAIN_MIN + 2·ATTN_T cycles, or more if ped wins the tie.
- No two roads are ever in GO or GO-ATTENTION at once. ped_walk=1 only while both roads are 00.

## Configuration
- PED_PHASE_EN defined: pedestrian phase, ped_pend and rr are implemented as above.
- PED_PHASE_EN undefined:
  - ped_req is ignored and ped_walk is tied 0.
  - PED state is absent, target is always side, and rr/ped_pend are removed.

## Test plan
All scenarios use default parameters; cycle 0 is the first cycle after reset release.
- No requests for 200 cycles → main_state=10, side_state=00, ped_walk=0 throughout.
- side_req held high from cycle 5:
  - MAIN_GO 0–29, MAIN_ATTN 30–32, SIDE_PREP 33–35.
  - SIDE_GO 36–95 (capped at 60), SIDE_ATTN 96–98, MAIN_PREP 99–101.
  - main_state=10 at 102.
- side_req one-cycle pulse at cycle 40 → MAIN_ATTN at 41. SIDE_GO lasts exactly 20 cycles (47–66). main_state=10 at 73.
- ped_req pulse at cycle 10, side_req low → MAIN_ATTN 30–32, ped_walk=1 for cycles 33–47, MAIN_PREP 48–50, main GO at 51.
- side_req and ped_req both rise at cycle 10, side_req held:
  - Side served first (rr=0).
  - After return to MAIN_GO, a further 30 cycles pass, then PED.
  - Checker confirms no overlapping GO at any cycle.
- rst_n=0 for one cycle during SIDE_GO with ped_pend set → next cycle main=10, side=00, ped_walk=0, and no PED follows without a new ped_req.
- Build without PED_PHASE_EN: ped_req pulses at cycles 10 and 50 → ped_walk stays 0 and main_state stays 10.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Phase scheduler sharing a crossing between main road, side road and pedestrians.
// Define PED_PHASE_EN to build the pedestrian phase; without it only main/side alternate.
module intersection_scheduler #(
    parameter int CNT_W     = 8,
    parameter int MAIN_MIN  = 30,
    parameter int SIDE_GO_T = 20,
    parameter int SIDE_MAX  = 60,
    parameter int PED_T     = 15,
    parameter int ATTN_T    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_state,
    output logic [1:0] side_state,
    output logic       ped_walk
);

    typedef enum logic [2:0] {
        S_MAIN_GO   = 3'd0,
        S_MAIN_ATTN = 3'd1,
        S_SIDE_PREP = 3'd2,
        S_SIDE_GO   = 3'd3,
        S_SIDE_ATTN = 3'd4,
        S_MAIN_PREP = 3'd5
`ifdef PED_PHASE_EN
        , S_PED     = 3'd6
`endif
    } state_t;

    localparam logic [1:0] L_STOP      = 2'b00;
    localparam logic [1:0] L_STOP_ATTN = 2'b01;
    localparam logic [1:0] L_GO        = 2'b10;
    localparam logic [1:0] L_GO_ATTN   = 2'b11;

    // Timer values on the last cycle of each phase.
    localparam logic [CNT_W-1:0] MAIN_MIN_LAST = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SIDE_GO_LAST  = CNT_W'(SIDE_GO_T - 1);
    localparam logic [CNT_W-1:0] SIDE_MAX_LAST = CNT_W'(SIDE_MAX - 1);
    localparam logic [CNT_W-1:0] ATTN_LAST     = CNT_W'(ATTN_T - 1);
`ifdef PED_PHASE_EN
    localparam logic [CNT_W-1:0] PED_LAST      = CNT_W'(PED_T - 1);
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic             any_req;

`ifdef PED_PHASE_EN
    logic ped_pend;
    logic rr;
    logic target_ped;
    logic pick_ped;
    logic leave_main;

    assign any_req    = side_req | ped_pend;
    assign pick_ped   = ped_pend & (~side_req | rr);
    assign leave_main = (state == S_MAIN_GO) && (state_next != S_MAIN_GO);
`else
    logic unused_ped_req;

    assign any_req        = side_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_MAIN_GO:
                if ((timer >= MAIN_MIN_LAST) && any_req)
                    state_next = S_MAIN_ATTN;
            S_MAIN_ATTN:
                if (timer == ATTN_LAST) begin
`ifdef PED_PHASE_EN
                    state_next = target_ped ? S_PED : S_SIDE_PREP;
`else
                    state_next = S_SIDE_PREP;
`endif
                end
            S_SIDE_PREP:
                if (timer == ATTN_LAST)
                    state_next = S_SIDE_GO;
            // Congestion keeps side green past its nominal time, up to the hard cap.
            S_SIDE_GO:
                if ((timer == SIDE_MAX_LAST) || ((timer >= SIDE_GO_LAST) && !side_req))
                    state_next = S_SIDE_ATTN;
            S_SIDE_ATTN:
                if (timer == ATTN_LAST)
                    state_next = S_MAIN_PREP;
`ifdef PED_PHASE_EN
            S_PED:
                if (timer == PED_LAST)
                    state_next = S_MAIN_PREP;
`endif
            S_MAIN_PREP:
                if (timer == ATTN_LAST)
                    state_next = S_MAIN_GO;
            default:
                state_next = S_MAIN_GO;
        endcase
    end

    // The timer restarts on every phase change and parks at all-ones while main rests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_MAIN_GO;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                timer <= '0;
            else if (!(&timer))
                timer <= timer + CNT_W'(1);
        end
    end

`ifdef PED_PHASE_EN
    // Entering PED consumes the pending request, even against a same-cycle press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pend   <= 1'b0;
            rr         <= 1'b0;
            target_ped <= 1'b0;
        end else begin
            if ((state_next == S_PED) && (state != S_PED))
                ped_pend <= 1'b0;
            else if (ped_req)
                ped_pend <= 1'b1;
            if (leave_main) begin
                target_ped <= pick_ped;
                if (side_req && ped_pend)
                    rr <= ~rr;
            end
        end
    end
`endif

    always_comb begin
        main_state = L_STOP;
        side_state = L_STOP;
        ped_walk   = 1'b0;
        case (state)
            S_MAIN_GO:   main_state = L_GO;
            S_MAIN_ATTN: main_state = L_GO_ATTN;
            S_SIDE_PREP: side_state = L_STOP_ATTN;
            S_SIDE_GO:   side_state = L_GO;
            S_SIDE_ATTN: side_state = L_GO_ATTN;
`ifdef PED_PHASE_EN
            S_PED:       ped_walk   = 1'b1;
`endif
            S_MAIN_PREP: main_state = L_STOP_ATTN;
            default: begin
                main_state = L_STOP;
                side_state = L_STOP;
                ped_walk   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: directed timelines queued per cycle, checked by a monitor.
// Honours PED_PHASE_EN the same way as the design.
module tb_intersection_scheduler;

    localparam logic [4:0] C_MG  = 5'b10_00_0;
    localparam logic [4:0] C_MA  = 5'b11_00_0;
    localparam logic [4:0] C_SP  = 5'b00_01_0;
    localparam logic [4:0] C_SG  = 5'b00_10_0;
    localparam logic [4:0] C_SA  = 5'b00_11_0;
    localparam logic [4:0] C_PED = 5'b00_00_1;
    localparam logic [4:0] C_MP  = 5'b01_00_0;

    logic       clk;
    logic       rst_n;
    logic       side_req;
    logic       ped_req;
    logic [1:0] main_state;
    logic [1:0] side_state;
    logic       ped_walk;

    typedef struct {
        string      name;
        int         cyc;
        logic [4:0] exp;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         seg_end[$];
    logic [4:0] seg_code[$];
    int         total_checks = 0;
    int         pass_checks  = 0;

    intersection_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_state (main_state),
        .side_state (side_state),
        .ped_walk   (ped_walk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, pending=%0d required=0", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic add_seg(input int e, input logic [4:0] c);
        seg_end.push_back(e);
        seg_code.push_back(c);
    endtask

    function automatic logic [4:0] exp_at(input int cyc);
        for (int i = 0; i < seg_end.size(); i++)
            if (cyc <= seg_end[i])
                return seg_code[i];
        return seg_code[seg_code.size() - 1];
    endfunction

    task automatic checkOutput(input string name, input int cyc, input logic [4:0] act, input logic [4:0] exp);
        total_checks++;
        if (act === exp)
            pass_checks++;
        else
            $display("[TB] FAIL %s cycle %0d: got main=%b side=%b walk=%b, required main=%b side=%b walk=%b",
                     name, cyc, act[4:3], act[2:1], act[0], exp[4:3], exp[2:1], exp[0]);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        side_req = 1'b0;
        ped_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Cycle 0 is the first cycle after reset release; inputs for cycle c are sampled at its closing edge.
    task automatic applyStimulus(input string tag, input int ncyc, input int side_from, input int side_to,
                                 input int ped_a, input int ped_b, input int rst_at);
        exp_t e;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            side_req = (c >= side_from) && (c <= side_to);
            ped_req  = (c == ped_a) || (c == ped_b);
            rst_n    = (c != rst_at);
            e = '{tag, c, exp_at(c)};
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        side_req = 1'b0;
        ped_req  = 1'b0;
        rst_n    = 1'b1;
        seg_end.delete();
        seg_code.delete();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput(mon_e.name, mon_e.cyc, {main_state, side_state, ped_walk}, mon_e.exp);
            total_checks++;
            if (!(main_state[1] && side_state[1]) && (!ped_walk || (main_state == 2'b00 && side_state == 2'b00)))
                pass_checks++;
            else
                $display("[TB] FAIL no_overlap %s cycle %0d: got main=%b side=%b walk=%b, required exclusive GO and walk only on all-stop",
                         mon_e.name, mon_e.cyc, main_state, side_state, ped_walk);
        end
    end

    initial begin
        rst_n    = 1'b0;
        side_req = 1'b0;
        ped_req  = 1'b0;

        add_seg(199, C_MG);
        applyStimulus("idle", 200, 0, -1, -1, -1, -1);

        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(35, C_SP); add_seg(95, C_SG);
        add_seg(98, C_SA); add_seg(101, C_MP); add_seg(119, C_MG);
        applyStimulus("side_held", 120, 5, 1000, -1, -1, -1);

        add_seg(40, C_MG); add_seg(43, C_MA); add_seg(46, C_SP); add_seg(66, C_SG);
        add_seg(69, C_SA); add_seg(72, C_MP); add_seg(79, C_MG);
        applyStimulus("side_pulse40", 80, 40, 40, -1, -1, -1);

        add_seg(59, C_MG);
        applyStimulus("side_pulse28", 60, 28, 28, -1, -1, -1);

        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(35, C_SP); add_seg(55, C_SG);
        add_seg(58, C_SA); add_seg(61, C_MP); add_seg(69, C_MG);
        applyStimulus("side_pulse29", 70, 29, 29, -1, -1, -1);

        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(35, C_SP); add_seg(61, C_SG);
        add_seg(64, C_SA); add_seg(67, C_MP); add_seg(79, C_MG);
        applyStimulus("side_extend", 80, 5, 60, -1, -1, -1);

        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(35, C_SP); add_seg(50, C_SG);
        add_seg(150, C_MG);
        applyStimulus("reset_mid", 151, 5, 49, 10, -1, 50);

`ifdef PED_PHASE_EN
        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(47, C_PED); add_seg(50, C_MP);
        add_seg(70, C_MG);
        applyStimulus("ped_only", 71, 0, -1, 10, -1, -1);

        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(35, C_SP); add_seg(95, C_SG);
        add_seg(98, C_SA); add_seg(101, C_MP); add_seg(131, C_MG); add_seg(134, C_MA);
        add_seg(149, C_PED); add_seg(152, C_MP); add_seg(169, C_MG);
        applyStimulus("both_tie", 170, 10, 1000, 10, -1, -1);

        add_seg(29, C_MG); add_seg(32, C_MA); add_seg(47, C_PED); add_seg(50, C_MP);
        add_seg(80, C_MG); add_seg(83, C_MA); add_seg(98, C_PED); add_seg(101, C_MP);
        add_seg(110, C_MG);
        applyStimulus("ped_rearm", 111, 0, -1, 10, 40, -1);
`else
        add_seg(99, C_MG);
        applyStimulus("no_ped", 100, 0, -1, 10, 50, -1);
`endif

        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            total_checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        #1;
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
